fp32_add_issue: RTL



---
 rtl/fp32_add_pkg.sv | 19 +
 rtl/fp_sync_fifo.sv | 61 ++++++
 rtl/fp32_add_issue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp32_add_pkg.sv
// fp32_add_pkg: shared constants and types for the FP32 add/subtract issue
// controller.
//   FP32_W / FP32_SIGN : word width and sign-bit position of an FP32 value
//   DEF_DEPTH          : default result-buffer depth / in-flight limit
//   DEF_TAG_W          : default caller-tag width
//   res_entry_t        : result-buffer entry {data, tag} at the default tag width
package fp32_add_pkg;

  localparam int unsigned FP32_W    = 32;
  localparam int unsigned FP32_SIGN = 31;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_TAG_W = 8;

  typedef struct packed {
    logic [FP32_W-1:0]    data;
    logic [DEF_TAG_W-1:0] tag;
  } res_entry_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: single-clock FIFO. The storage, pointers and occupancy count
// are all registers, and the head is read straight from the storage array.
// A push lands on the clock edge, so a word pushed in cycle N becomes visible
// at dout with empty = 0 in cycle N+1.
//   clk, rst : clock, synchronous active-high reset (clears storage to zero)
//   push/din : write request and data; ignored while full
//   pop      : read request; ignored while empty
//   dout     : head entry
//   full     : count == DEPTH
//   empty    : count == 0
module fp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp32_add_issue.sv
// fp32_add_issue: operand-issue and result-collection controller for the
// pipelined FP32 add/subtract core.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand-pair stream (in_a, in_b, in_sub, in_tag)
//   core_a_* / core_b_*   : one-cycle operand pulses to the core; B carries the
//                           sign flipped for subtract
//   core_result_*         : core result stream, no backpressure
//   out_valid/out_ready   : in-order result stream (out_data, out_tag)
//   err                   : sticky protocol error, only when FP32_ADD_ISSUE_ERR_EN
//                           is defined
// A credit counter limits work in flight to DEPTH, which is the result-buffer
// size, so a result is never lost while the consumer stalls.
module fp32_add_issue
  import fp32_add_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_a,
  input  logic [FP32_W-1:0] in_b,
  input  logic              in_sub,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              core_a_tvalid,
  output logic [FP32_W-1:0] core_a_tdata,
  output logic              core_b_tvalid,
  output logic [FP32_W-1:0] core_b_tdata,
  input  logic              core_result_tvalid,
  input  logic [FP32_W-1:0] core_result_tdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef FP32_ADD_ISSUE_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [FP32_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic [CW-1:0]    credit;
  logic             accept;
  logic             out_fire;
  logic             res_push;
  logic [TAG_W-1:0] tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic             res_full;
  logic             res_empty;
  entry_t           res_in;
  entry_t           res_head;

  assign in_ready = (credit < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // A result with no tag waiting has no owner and is dropped.
  assign res_push = core_result_tvalid && !tag_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= '0;
    end else begin
      case ({accept, out_fire})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  // Operand issue register: the valids pulse for one cycle per accept and
  // the data holds its last value in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_a_tvalid <= 1'b0;
      core_b_tvalid <= 1'b0;
      core_a_tdata  <= '0;
      core_b_tdata  <= '0;
    end else begin
      core_a_tvalid <= accept;
      core_b_tvalid <= accept;
      if (accept) begin
        core_a_tdata <= in_a;
        core_b_tdata <= {in_b[FP32_SIGN] ^ in_sub, in_b[FP32_SIGN-1:0]};
      end
    end
  end

  fp_sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (in_tag),
    .pop   (res_push),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_comb begin
    res_in      = '0;
    res_in.data = core_result_tdata;
    res_in.tag  = tag_head;
  end

  fp_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .din   (res_in),
    .pop   (out_fire),
    .dout  (res_head),
    .full  (res_full),
    .empty (res_empty)
  );

  assign out_valid = !res_empty;
  assign out_data  = res_head.data;
  assign out_tag   = res_head.tag;

`ifdef FP32_ADD_ISSUE_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((core_result_tvalid && tag_empty) || (res_push && res_full)) begin
      err <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, tag_full};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, tag_full, res_full};
`endif

endmodule
